seg_scan_controller: RTL and testbench

- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Shares one downstream BCD-to-segment decoder across all digits. It presents one 4-bit digit code at a time, together with an active-low one-hot anode select.
- Inserts inter-digit blanking to suppress ghosting.
- Sits between the keyboard/display logic, which supplies packed BCD digits, and the seven-segment decoder plus board anode pins.

---
 rtl/seg_scan_controller_if.sv | 34 +++
 rtl/seg_scan_controller.sv | 167 ++++++++++++++++
 tb/tb_seg_scan_controller.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_controller_if
// Description : Bundle between the display logic (master) and the 7-segment
//               scan controller (slave): scan control, packed BCD digits,
//               digit enables, and the shared-decoder / anode outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_controller_if #(
  parameter int NUM_DIGITS = 8,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [3:0]              digit_code;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [IDX_W-1:0]        scan_idx;
  logic                    frame_start;

  // Display logic side: supplies digits and control, observes scan status
  modport master (
    output enable, load, digits_in, digit_en,
    input  digit_code, an_n, scan_idx, frame_start
  );

  // Scan controller side
  modport slave (
    input  enable, load, digits_in, digit_en,
    output digit_code, an_n, scan_idx, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_controller
// Description : Time-multiplexed scan controller for an N-digit common-anode
//               7-segment display. Presents one digit code at a time to a
//               shared BCD decoder with an active-low one-hot anode select,
//               and blanks all anodes at the end of every slot.
//               Optional macro SEG_SCAN_LZ_BLANK_EN enables leading-zero
//               suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_controller #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 100000,
  parameter int BLANK_CYC  = 16,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_scan_controller_if.slave bus
);

  localparam int               CNT_W       = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] c_show_last = CNT_W'(CLK_DIV - BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] c_slot_last = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_prescale;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [IDX_W-1:0]        r_idx;
  logic [3:0]              r_code;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic                    r_frame;

  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic [IDX_W-1:0]        w_next_idx;
  logic                    w_lit;
  logic [3:0]              w_next_code;
  logic [NUM_DIGITS-1:0]   w_next_an_n;

`ifdef SEG_SCAN_LZ_BLANK_EN
  // Marks every zero digit above the most significant nonzero digit.
  // Digit 0 is never marked so a value of zero still shows a single "0".
  function automatic logic [NUM_DIGITS-1:0] f_lz_mask(
    input logic [4*NUM_DIGITS-1:0] digits
  );
    logic seen;
    f_lz_mask = '0;
    seen      = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (digits[4*i +: 4] != 4'd0) seen = 1'b1;
      f_lz_mask[i] = ~seen;
    end
  endfunction

  logic [NUM_DIGITS-1:0] r_lz_mask;

  // Suppression mask follows the shadow register, refreshed on every load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lz_mask <= f_lz_mask({4*NUM_DIGITS{1'b0}});
    end else if (bus.load) begin
      r_lz_mask <= f_lz_mask(bus.digits_in);
    end
  end

  assign w_lz_mask = r_lz_mask;
`else
  assign w_lz_mask = '0;
`endif

  // Outputs for the slot about to enter SHOW: index 0 from IDLE, otherwise
  // the successor of the current index (only consumed on SHOW entry).
  always_comb begin
    w_next_idx = '0;
    if (r_state == ST_BLANK && r_idx != c_idx_last) begin
      w_next_idx = r_idx + 1'b1;
    end
    w_lit       = bus.digit_en[w_next_idx] & ~w_lz_mask[w_next_idx];
    w_next_code = w_lit ? r_shadow[{w_next_idx, 2'b00} +: 4] : 4'hF;
    w_next_an_n = w_lit ? ~(NUM_DIGITS'(1) << w_next_idx) : '1;
  end

  // Scan FSM with shadow capture; code and anode are sampled only on SHOW
  // entry so a mid-slot load never tears the digit currently shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_prescale <= '0;
      r_shadow   <= '0;
      r_idx      <= '0;
      r_code     <= 4'hF;
      r_an_n     <= '1;
      r_frame    <= 1'b0;
    end else begin
      if (bus.load) begin
        r_shadow <= bus.digits_in;
      end

      if (!bus.enable) begin
        r_state    <= ST_IDLE;
        r_prescale <= '0;
        r_idx      <= '0;
        r_code     <= 4'hF;
        r_an_n     <= '1;
        r_frame    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state    <= ST_SHOW;
            r_prescale <= '0;
            r_idx      <= '0;
            r_code     <= w_next_code;
            r_an_n     <= w_next_an_n;
            r_frame    <= 1'b1;
          end

          ST_SHOW: begin
            r_frame    <= 1'b0;
            r_prescale <= r_prescale + 1'b1;
            if (r_prescale == c_show_last) begin
              r_state <= ST_BLANK;
              r_an_n  <= '1;
            end
          end

          ST_BLANK: begin
            r_frame <= 1'b0;
            if (r_prescale == c_slot_last) begin
              r_state    <= ST_SHOW;
              r_prescale <= '0;
              r_idx      <= w_next_idx;
              r_code     <= w_next_code;
              r_an_n     <= w_next_an_n;
              r_frame    <= (w_next_idx == '0);
            end else begin
              r_prescale <= r_prescale + 1'b1;
            end
          end

          default: begin
            r_state    <= ST_IDLE;
            r_prescale <= '0;
            r_idx      <= '0;
            r_code     <= 4'hF;
            r_an_n     <= '1;
            r_frame    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.digit_code  = r_code;
  assign bus.an_n        = r_an_n;
  assign bus.scan_idx    = r_idx;
  assign bus.frame_start = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_controller
// Description : Self-checking bench for seg_scan_controller (4 digits,
//               8 cycles per slot, 2 blank cycles). Expected slot contents
//               are pushed to a scoreboard and compared cycle by cycle.
//               Define SEG_SCAN_LZ_BLANK_EN to also cover leading-zero
//               suppression.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_controller;

  localparam int ND = 4;
  localparam int CD = 8;
  localparam int BC = 2;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] code;
    logic [3:0] an;
    logic       frame;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  slot_t       sb[$];
  logic [15:0] m_shadow;
  logic [15:0] m_pend_val;
  logic        m_pend;
  logic [3:0]  m_en;
  int          m_idx;

  seg_scan_controller_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_controller #(
    .NUM_DIGITS(ND),
    .CLK_DIV   (CD),
    .BLANK_CYC (BC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Safety net in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic slot_t cur_out();
    slot_t a;
    a.idx   = bus.scan_idx;
    a.code  = bus.digit_code;
    a.an    = bus.an_n;
    a.frame = bus.frame_start;
    return a;
  endfunction

  // Reference: what one slot should show given the model shadow and mask
  function automatic slot_t model_slot(input int idx);
    slot_t       s;
    logic [15:0] tmp;
    logic [3:0]  sup;
    logic        lit;
    sup = 4'b0000;
`ifdef SEG_SCAN_LZ_BLANK_EN
    begin
      logic leading;
      leading = 1'b1;
      for (int i = ND - 1; i > 0; i--) begin
        tmp = m_shadow >> (4 * i);
        if (leading && tmp[3:0] == 4'd0) sup[i] = 1'b1;
        else leading = 1'b0;
      end
    end
`endif
    tmp     = m_shadow >> (4 * idx);
    lit     = m_en[idx] && !sup[idx];
    s.idx   = 2'(idx);
    s.code  = lit ? tmp[3:0] : 4'hF;
    s.an    = lit ? ~(4'b0001 << idx) : 4'hF;
    s.frame = (idx == 0);
    return s;
  endfunction

  // Checks one full slot starting at its first SHOW cycle; optionally pulses
  // load with load_val during cycle load_at (-1 for none).
  task automatic run_slot(input int load_at, input logic [15:0] load_val);
    slot_t exp_s, e, act;
    sb.push_back(model_slot(m_idx));
    if (m_pend) begin
      m_shadow = m_pend_val;
      m_pend   = 1'b0;
    end
    exp_s = sb.pop_front();
    for (int c = 0; c < CD; c++) begin
      e = exp_s;
      if (c > 0)       e.frame = 1'b0;
      if (c >= CD - BC) e.an   = 4'hF;
      act = cur_out();
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL slot%0d_cyc%0d: got idx=%0d code=%h an=%b fs=%b, expected idx=%0d code=%h an=%b fs=%b",
                 m_idx, c, act.idx, act.code, act.an, act.frame, e.idx, e.code, e.an, e.frame);
      end
      if (c == load_at) begin
        bus.load      = 1'b1;
        bus.digits_in = load_val;
        if (c == CD - 1) begin
          m_pend     = 1'b1;
          m_pend_val = load_val;
        end
      end else begin
        bus.load = 1'b0;
      end
      step();
    end
    bus.load = 1'b0;
    if (load_at >= 0 && load_at < CD - 1) m_shadow = load_val;
    m_idx = (m_idx + 1) % ND;
  endtask

  task automatic check_idle(input string name);
    slot_t act, e;
    e   = '{idx: 2'd0, code: 4'hF, an: 4'hF, frame: 1'b0};
    act = cur_out();
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got idx=%0d code=%h an=%b fs=%b, expected idx=0 code=f an=1111 fs=0",
               name, act.idx, act.code, act.an, act.frame);
    end
  endtask

  task automatic do_load(input logic [15:0] val);
    bus.load      = 1'b1;
    bus.digits_in = val;
    step();
    bus.load = 1'b0;
    m_shadow = val;
  endtask

  task automatic restart(input logic [3:0] en);
    bus.enable   = 1'b0;
    step();
    bus.digit_en = en;
    m_en         = en;
    bus.enable   = 1'b1;
    step();
    m_idx = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    check_idle("reset_values");
    rst_n = 1'b1;
    step();
    check_idle("idle_disabled");
  endtask

  task automatic test_basic_scan();
    do_load(16'h4321);
    bus.digit_en = 4'hF;
    m_en         = 4'hF;
    bus.enable   = 1'b1;
    step();
    m_idx = 0;
    repeat (2 * ND) run_slot(-1, 16'h0);
  endtask

  task automatic test_digit_mask();
    restart(4'b1011);
    repeat (ND) run_slot(-1, 16'h0);
    restart(4'hF);
  endtask

  task automatic test_load_mid_slot();
    run_slot(-1, 16'h0);
    run_slot(3, 16'h9876);
    repeat (ND) run_slot(-1, 16'h0);
  endtask

  task automatic test_load_at_entry();
    run_slot(-1, 16'h0);
    run_slot(CD - 1, 16'h5555);
    repeat (ND - 2) run_slot(-1, 16'h0);
    run_slot(-1, 16'h0);
  endtask

  task automatic test_enable_drop();
    while (m_idx != 0) run_slot(-1, 16'h0);
    run_slot(-1, 16'h0);
    run_slot(-1, 16'h0);
    step();
    step();
    bus.enable = 1'b0;
    step();
    check_idle("enable_drop");
    step();
    check_idle("enable_drop_hold");
    bus.enable = 1'b1;
    step();
    m_idx = 0;
    run_slot(-1, 16'h0);
  endtask

  task automatic test_async_reset();
    repeat (CD - BC) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset_immediate");
    step();
    check_idle("async_reset_held");
    rst_n    = 1'b1;
    m_shadow = 16'h0000;
    step();
    m_idx = 0;
    run_slot(-1, 16'h0);
  endtask

`ifdef SEG_SCAN_LZ_BLANK_EN
  task automatic test_lz_blank();
    bus.enable = 1'b0;
    step();
    do_load(16'h0050);
    restart(4'hF);
    repeat (ND) run_slot(-1, 16'h0);
    bus.enable = 1'b0;
    step();
    do_load(16'h0000);
    restart(4'hF);
    repeat (ND) run_slot(-1, 16'h0);
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = '0;
    bus.digit_en  = 4'hF;
    m_shadow      = '0;
    m_pend        = 1'b0;
    m_pend_val    = '0;
    m_en          = 4'hF;
    m_idx         = 0;

    test_reset();
    test_basic_scan();
    test_digit_mask();
    test_load_mid_slot();
    test_load_at_entry();
    test_enable_drop();
    run_slot(-1, 16'h0);
    test_async_reset();
`ifdef SEG_SCAN_LZ_BLANK_EN
    test_lz_blank();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
